// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants: fetch FSM state encoding, NOP word and datapath width.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam int          MIPS_WORD_W = 32;
    localparam logic [31:0] MIPS_NOP    = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry skid register that parks an instruction word accepted while the decode stage is stalled.
module fetch_skid_buf
    import mips_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   clear,
    input  logic                   unload,
    input  logic [MIPS_WORD_W-1:0] load_data,
    output logic [MIPS_WORD_W-1:0] data,
    output logic                   valid
);

    logic [MIPS_WORD_W-1:0] data_q, data_d;
    logic                   valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clear || unload) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC, imem req/ack handshake and IF/ID register.
// Optional FETCH_STALL_CNT_EN adds a saturating stall_cycles counter output.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus1,
`ifdef FETCH_STALL_CNT_EN
    output logic [31:0] stall_cycles,
`endif
    output logic [31:0] ifid_instr
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic [31:0]  ifid_pc_q, ifid_pc_d;
    logic [31:0]  ifid_pc_plus1_q, ifid_pc_plus1_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;

    logic         xfer;
    logic         capture;
    logic [31:0]  capture_word;
    logic         skid_load, skid_clear, skid_unload;
    logic [31:0]  skid_data;
    logic         skid_valid;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .clear     (skid_clear),
        .unload    (skid_unload),
        .load_data (imem_rdata),
        .data      (skid_data),
        .valid     (skid_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirects always resume in FETCH; the new address goes out next cycle.
    always_comb begin
        state_d = state_q;
        if (branch_taken || flush) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                IDLE:    state_d = FETCH;
                FETCH:   if (xfer && stall) state_d = HOLD;
                HOLD:    if (!stall && skid_valid) state_d = FETCH;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req  = (state_q == FETCH);
        imem_addr = pc_q;
    end

    assign xfer = imem_req && imem_ack;

    always_comb begin
        pc_d            = pc_q;
        ifid_valid_d    = ifid_valid_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus1_d = ifid_pc_plus1_q;
        ifid_instr_d    = ifid_instr_q;
        skid_load       = 1'b0;
        skid_clear      = 1'b0;
        skid_unload     = 1'b0;
        capture         = 1'b0;
        capture_word    = imem_rdata;

        if (branch_taken) begin
            pc_d         = branch_target;
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            skid_clear   = 1'b1;
        end else if (flush) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            skid_clear   = 1'b1;
        end else begin
            case (state_q)
                FETCH: begin
                    if (xfer && stall)   skid_load    = 1'b1;
                    else if (xfer)       capture      = 1'b1;
                    else if (!stall)     ifid_valid_d = 1'b0;
                end
                HOLD: begin
                    if (!stall && skid_valid) begin
                        capture      = 1'b1;
                        capture_word = skid_data;
                        skid_unload  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (capture) begin
            ifid_valid_d    = 1'b1;
            ifid_pc_d       = pc_q;
            ifid_pc_plus1_d = pc_q + 32'd1;
            ifid_instr_d    = capture_word;
            pc_d            = pc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q            <= RESET_PC;
            ifid_valid_q    <= 1'b0;
            ifid_pc_q       <= '0;
            ifid_pc_plus1_q <= '0;
            ifid_instr_q    <= NOP_INSTR;
        end else begin
            pc_q            <= pc_d;
            ifid_valid_q    <= ifid_valid_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus1_q <= ifid_pc_plus1_d;
            ifid_instr_q    <= ifid_instr_d;
        end
    end

    assign ifid_valid    = ifid_valid_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus1 = ifid_pc_plus1_q;
    assign ifid_instr    = ifid_instr_q;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == FETCH || state_q == HOLD) && stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stall/flush/branch/ack traffic vs a queue-based model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, branch_taken, imem_ack;
    logic [31:0] branch_target, imem_rdata;
    logic        imem_req, ifid_valid;
    logic [31:0] imem_addr, ifid_pc, ifid_pc_plus1, ifid_instr;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] stall_cycles2;
`endif

    logic        rst2_n;
    logic        req2, valid2;
    logic [31:0] addr2, pc2, pc1_2, instr2, rdata2;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus1 (ifid_pc_plus1),
`ifdef FETCH_STALL_CNT_EN
        .stall_cycles  (stall_cycles),
`endif
        .ifid_instr    (ifid_instr)
    );

    // Wrap-around instance: free-running memory that always acks with addr+100.
    assign rdata2 = addr2 + 32'd100;

    fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) u_wrap (
        .clk           (clk),
        .rst_n         (rst2_n),
        .stall         (1'b0),
        .flush         (1'b0),
        .branch_taken  (1'b0),
        .branch_target (32'h0),
        .imem_req      (req2),
        .imem_addr     (addr2),
        .imem_ack      (1'b1),
        .imem_rdata    (rdata2),
        .ifid_valid    (valid2),
        .ifid_pc       (pc2),
        .ifid_pc_plus1 (pc1_2),
`ifdef FETCH_STALL_CNT_EN
        .stall_cycles  (stall_cycles2),
`endif
        .ifid_instr    (instr2)
    );

    // Reference model: a pending-bubble flag, the PC, and at most one parked word.
    bit          m_idle;
    logic [31:0] m_pc;
    logic [31:0] m_held[$];
    logic        m_v;
    logic [31:0] m_ipc, m_ipc1, m_instr;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic m_req();
        return !m_idle && (m_held.size() == 0);
    endfunction

    task automatic model_reset();
        m_idle  = 1'b1;
        m_pc    = 32'h0;
        m_held.delete();
        m_v     = 1'b0;
        m_ipc   = 32'h0;
        m_ipc1  = 32'h0;
        m_instr = 32'h0;
        m_cnt   = 32'h0;
    endtask

    task automatic model_capture(input logic [31:0] w);
        m_v     = 1'b1;
        m_ipc   = m_pc;
        m_ipc1  = m_pc + 32'd1;
        m_instr = w;
        m_pc    = m_pc + 32'd1;
    endtask

    task automatic model_step();
        if (!m_idle && stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (branch_taken) begin
            m_pc = branch_target; m_v = 1'b0; m_instr = 32'h0; m_held.delete(); m_idle = 1'b0;
        end else if (flush) begin
            m_v = 1'b0; m_instr = 32'h0; m_held.delete(); m_idle = 1'b0;
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else if (m_held.size() != 0) begin
            if (!stall) model_capture(m_held.pop_front());
        end else if (imem_ack) begin
            if (stall) m_held.push_back(imem_rdata);
            else       model_capture(imem_rdata);
        end else if (!stall) begin
            m_v = 1'b0;
        end
    endtask

    task automatic check_all();
        check("req",   {31'h0, imem_req},   {31'h0, m_req()});
        if (m_req()) check("addr", imem_addr, m_pc);
        check("valid", {31'h0, ifid_valid}, {31'h0, m_v});
        check("pc",    ifid_pc,       m_ipc);
        check("pc1",   ifid_pc_plus1, m_ipc1);
        check("instr", ifid_instr,    m_instr);
`ifdef FETCH_STALL_CNT_EN
        check("stall_cnt", stall_cycles, m_cnt);
`endif
    endtask

    // Called at a falling edge: check, drive, advance the model, move to the next falling edge.
    task automatic cycle(input logic s, input logic f, input logic b,
                         input logic [31:0] tgt, input logic a);
        check_all();
        stall         = s;
        flush         = f;
        branch_taken  = b;
        branch_target = tgt;
        imem_ack      = a;
        imem_rdata    = m_pc + 32'd100;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_to_pc(input logic [31:0] target);
        for (int k = 0; k < 200 && !(m_req() && m_pc == target); k++) cycle(0, 0, 0, 32'h0, 1);
        check("reach_pc", m_pc, target);
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        stall = 0; flush = 0; branch_taken = 0; branch_target = 0; imem_ack = 0; imem_rdata = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("rst_req",   {31'h0, imem_req},   32'h0);
        check("rst_valid", {31'h0, ifid_valid}, 32'h0);
        check("rst_instr", ifid_instr, 32'h0);
        check("rst_pc1",   ifid_pc_plus1, 32'h0);
        rst_n = 1'b1;

        // Startup bubble, then back-to-back capture with rdata = addr+100.
        cycle(0, 0, 0, 32'h0, 1);
        check("first_req",  {31'h0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h0);
        cycle(0, 0, 0, 32'h0, 1);
        check("cap0", ifid_instr, 32'd100);
        cycle(0, 0, 0, 32'h0, 1);
        check("cap1", ifid_instr, 32'd101);

        // Ack at pc=5 under a 3-cycle stall.
        run_to_pc(32'd5);
        cycle(1, 0, 0, 32'h0, 1);
        cycle(1, 0, 0, 32'h0, 1);
        check("hold_req", {31'h0, imem_req}, 32'h0);
        cycle(1, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 32'h0, 0);
        check("unstall_pc",    ifid_pc, 32'd5);
        check("unstall_instr", ifid_instr, 32'd105);
        check("unstall_addr",  imem_addr, 32'd6);

        // Branch colliding with the ack for pc=7.
        run_to_pc(32'd7);
        cycle(0, 0, 1, 32'h40, 1);
        check("br_valid", {31'h0, ifid_valid}, 32'h0);
        check("br_addr",  imem_addr, 32'h40);
        cycle(0, 0, 0, 32'h0, 1);
        check("br_cap", ifid_instr, 32'h40 + 32'd100);

        // Flush colliding with the ack for pc=9, then refetch.
        cycle(0, 0, 1, 32'd9, 0);
        cycle(0, 1, 0, 32'h0, 1);
        check("fl_valid", {31'h0, ifid_valid}, 32'h0);
        cycle(0, 0, 0, 32'h0, 1);
        check("fl_pc",    ifid_pc, 32'd9);
        check("fl_pc1",   ifid_pc_plus1, 32'd10);
        check("fl_instr", ifid_instr, 32'd109);

        // Four stalled FETCH cycles with no ack.
        begin
            logic [31:0] c0;
            c0 = m_cnt;
            for (int k = 0; k < 4; k++) cycle(1, 0, 0, 32'h0, 0);
            check("cnt_model_delta", m_cnt - c0, 32'd4);
        end

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom_range(0, 63);
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, tgt, $urandom_range(0, 2) != 0);
        end

        // Asynchronous reset in the middle of a stalled fetch.
        cycle(1, 0, 0, 32'h0, 0);
        cycle(1, 0, 0, 32'h0, 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_req",   {31'h0, imem_req},   32'h0);
        check("arst_valid", {31'h0, ifid_valid}, 32'h0);
`ifdef FETCH_STALL_CNT_EN
        check("arst_cnt", stall_cycles, 32'h0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) cycle(0, 0, 0, 32'h0, 1);
        check_all();

        // PC wrap from RESET_PC = FFFF_FFFF.
        @(negedge clk);
        rst2_n = 1'b1;
        check("wrap_bubble", {31'h0, req2}, 32'h0);
        @(negedge clk);
        check("wrap_req",  {31'h0, req2}, 32'h1);
        check("wrap_addr", addr2, 32'hFFFF_FFFF);
        @(negedge clk);
        check("wrap_valid", {31'h0, valid2}, 32'h1);
        check("wrap_pc",    pc2, 32'hFFFF_FFFF);
        check("wrap_pc1",   pc1_2, 32'h0);
        check("wrap_instr", instr2, 32'd99);
        check("wrap_next",  addr2, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
